ysyx_24090018_ifu: RTL

Instruction fetch stage for the multi-cycle NPC core. It sits directly upstream of the decode stage. The block holds the PC and issues one 32-bit fetch request per instruction over a valid/ready memory port. It captures the returned word and presents it to decode with a valid/ready handshake, then waits for the next-PC redirect from the execute/writeback path before fetching again.

---
 rtl/ysyx_24090018_ifu.sv | 95 +++++++++
 1 files changed

// File: rtl/ysyx_24090018_ifu.sv
// Multi-cycle instruction fetch stage: holds the PC, fetches one word per instruction, hands it to decode.
// Define YSYX_24090018_IFU_ALIGN_CHECK_EN to trap misaligned next-PC values in a sticky FAULT state.
module ysyx_24090018_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    input  logic [ADDR_WIDTH-1:0] npc_i,
    input  logic                  npc_valid_i,
    output logic                  fault_o
);

`ifdef YSYX_24090018_IFU_ALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, WAIT_NPC, FAULT} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, WAIT_NPC} state_t;

    // Without the alignment trap, the low two PC bits are simply forced to zero.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
`endif

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [DATA_WIDTH-1:0] inst, inst_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            inst  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            inst  <= inst_next;
        end
    end

    // Read data is only sampled in WAIT, so a response left over from an aborted fetch is dropped.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        inst_next       = inst;
        mem_req_valid_o = 1'b0;
        inst_valid_o    = 1'b0;
        fault_o         = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_next = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    inst_next  = mem_rdata_i;
                    state_next = OUT;
                end
            end
            OUT: begin
                inst_valid_o = 1'b1;
                if (inst_ready_i) state_next = WAIT_NPC;
            end
            WAIT_NPC: begin
                if (npc_valid_i) begin
`ifdef YSYX_24090018_IFU_ALIGN_CHECK_EN
                    pc_next    = npc_i;
                    state_next = (npc_i[1:0] != 2'b00) ? FAULT : REQ;
`else
                    pc_next    = npc_i & ALIGN_MASK;
                    state_next = REQ;
`endif
                end
            end
`ifdef YSYX_24090018_IFU_ALIGN_CHECK_EN
            FAULT: fault_o = 1'b1;
`endif
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr_o = pc;
    assign pc_o       = pc;
    assign inst_o     = inst;

endmodule
